// File: rtl/sequenciador_quadro_if.sv
// Byte stream from the frame sequencer to the OLED byte driver (SPI/I2C).
// A byte transfers on a rising edge where byte_valido && byte_pronto; once byte_valido rises, byte_saida/byte_dc hold until that edge.
interface sequenciador_quadro_if;
    logic [7:0] byte_saida;
    logic       byte_dc;
    logic       byte_valido;
    logic       byte_pronto;

    modport master (output byte_saida, output byte_dc, output byte_valido, input byte_pronto);
    modport slave  (input byte_saida, input byte_dc, input byte_valido, output byte_pronto);
endinterface

// File: rtl/sequenciador_quadro.sv
// SSD1306 frame sequencer: sends the init ROM once after reset, then on each refresh
// snapshots the image and streams 6 addressing commands plus N_BYTES data bytes.
module sequenciador_quadro #(
    parameter int N_BYTES = 1024,
    parameter int N_INIT  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_BYTES*8-1:0]   imagem,
    input  logic                   atualizar,
    sequenciador_quadro_if.master  bus,
    output logic                   ocupado,
    output logic                   quadro_concluido,
    output logic [2:0]             estado
);
    localparam int CW = $clog2(N_BYTES);

    typedef enum logic [2:0] {
        INIT         = 3'd0,
        OCIOSO       = 3'd1,
        CMD_ENDERECO = 3'd2,
        DADOS        = 3'd3,
        FIM          = 3'd4
    } estado_t;

    estado_t              st;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_prox;
    logic                 pendente;
    logic                 captura;
    logic                 aceito;
    logic [N_BYTES*8-1:0] sombra;

    function automatic logic [7:0] rom_init(input logic [2:0] i);
        case (i)
            3'd0:    rom_init = 8'hAE;
            3'd1:    rom_init = 8'h20;
            3'd2:    rom_init = 8'h00;
            3'd3:    rom_init = 8'h8D;
            3'd4:    rom_init = 8'h14;
            default: rom_init = 8'hAF;
        endcase
    endfunction

    function automatic logic [7:0] rom_endereco(input logic [2:0] i);
        case (i)
            3'd0:    rom_endereco = 8'h21;
            3'd1:    rom_endereco = 8'h00;
            3'd2:    rom_endereco = 8'h7F;
            3'd3:    rom_endereco = 8'h22;
            3'd4:    rom_endereco = 8'h00;
            default: rom_endereco = 8'h07;
        endcase
    endfunction

    assign cnt_prox = cnt + 1'b1;
    assign aceito   = bus.byte_valido && bus.byte_pronto;
    assign estado   = st;
    // FIM may chain straight into the next frame, so it captures exactly like OCIOSO.
    assign captura  = !reset && (st == OCIOSO || st == FIM) && (atualizar || pendente);

    always_ff @(posedge clk) begin
        if (captura) sombra <= imagem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st               <= INIT;
            cnt              <= '0;
            pendente         <= 1'b0;
            bus.byte_valido  <= 1'b0;
            bus.byte_saida   <= 8'h00;
            bus.byte_dc      <= 1'b0;
            quadro_concluido <= 1'b0;
            ocupado          <= 1'b1;
        end else begin
            quadro_concluido <= 1'b0;
            if (atualizar && st != OCIOSO) pendente <= 1'b1;
            case (st)
                INIT: begin
                    if (!bus.byte_valido) begin
                        bus.byte_valido <= 1'b1;
                        bus.byte_saida  <= rom_init(cnt[2:0]);
                        bus.byte_dc     <= 1'b0;
                    end else if (aceito) begin
                        if (cnt == CW'(N_INIT - 1)) begin
                            st              <= OCIOSO;
                            cnt             <= '0;
                            bus.byte_valido <= 1'b0;
                            ocupado         <= 1'b0;
                        end else begin
                            cnt            <= cnt_prox;
                            bus.byte_saida <= rom_init(cnt_prox[2:0]);
                        end
                    end
                end
                OCIOSO, FIM: begin
                    if (captura) begin
                        st              <= CMD_ENDERECO;
                        cnt             <= '0;
                        pendente        <= 1'b0;
                        ocupado         <= 1'b1;
                        bus.byte_valido <= 1'b1;
                        bus.byte_saida  <= rom_endereco(3'd0);
                        bus.byte_dc     <= 1'b0;
                    end else begin
                        st      <= OCIOSO;
                        ocupado <= 1'b0;
                    end
                end
                CMD_ENDERECO: begin
                    if (aceito) begin
                        if (cnt == CW'(5)) begin
                            st             <= DADOS;
                            cnt            <= '0;
                            bus.byte_saida <= sombra[7:0];
                            bus.byte_dc    <= 1'b1;
                        end else begin
                            cnt            <= cnt_prox;
                            bus.byte_saida <= rom_endereco(cnt_prox[2:0]);
                        end
                    end
                end
                DADOS: begin
                    if (aceito) begin
                        if (cnt == CW'(N_BYTES - 1)) begin
                            st               <= FIM;
                            cnt              <= '0;
                            bus.byte_valido  <= 1'b0;
                            quadro_concluido <= 1'b1;
                        end else begin
                            cnt            <= cnt_prox;
                            bus.byte_saida <= sombra[{cnt_prox, 3'b000} +: 8];
                        end
                    end
                end
                default: st <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sequenciador_quadro.sv
// Directed bench for sequenciador_quadro: observed byte stream is compared with an
// expected queue built from the bench's own image copy and the fixed command ROMs.
module tb_sequenciador_quadro;
    localparam int NB = 1024;
    localparam int BUDGET = 20000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            atualizar = 1'b0;
    logic [NB*8-1:0] imagem = '0;
    logic            ocupado;
    logic            quadro_concluido;
    logic [2:0]      estado;

    sequenciador_quadro_if bus();

    sequenciador_quadro #(.N_BYTES(NB), .N_INIT(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .imagem           (imagem),
        .atualizar        (atualizar),
        .bus              (bus),
        .ocupado          (ocupado),
        .quadro_concluido (quadro_concluido),
        .estado           (estado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    // per-collection observations
    int   cyc, target, stab_err, conc_cnt, gap_cnt, idle_mid;
    int   first_push_cyc, last_push_cyc, conc_cyc, sw_at;
    logic conc_valido, ocup_after_conc, last_ocupado, last_valido;
    bit   conc_prev, start_pulse, upd_mid, hold_upd;
    logic prev_v, prev_p;
    logic [8:0] prev_b;

    initial bus.byte_pronto = 1'b0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

    task automatic exp_init();
        exp_q.push_back({1'b0, 8'hAE}); exp_q.push_back({1'b0, 8'h20});
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'h8D});
        exp_q.push_back({1'b0, 8'h14}); exp_q.push_back({1'b0, 8'hAF});
    endtask

    task automatic exp_frame(input logic [NB*8-1:0] img);
        exp_q.push_back({1'b0, 8'h21}); exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h7F}); exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'h07});
        for (int i = 0; i < NB; i++) exp_q.push_back({1'b1, img[i*8 +: 8]});
    endtask

    function automatic logic [NB*8-1:0] ramp();
        logic [NB*8-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = i[7:0];
        return r;
    endfunction

    function automatic int first_mism();
        for (int i = 0; i < obs_q.size(); i++)
            if (i >= exp_q.size() || obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() < exp_q.size()) return obs_q.size();
        return -1;
    endfunction

    function automatic logic [8:0] obs_at(input int i);
        return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 9'bx;
    endfunction

    function automatic logic [8:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 9'bx;
    endfunction

    // One clock: drive inputs at the falling edge, then record what the DUT shows.
    task automatic cycle_step(input int pct);
        @(negedge clk);
        cyc++;
        bus.byte_pronto = ($urandom_range(0, 99) < pct);
        atualizar = hold_upd || (start_pulse && cyc == 1) ||
                    (upd_mid && (obs_q.size() == 200 || obs_q.size() == 400 || obs_q.size() == 600));
        if (sw_at >= 0 && obs_q.size() == sw_at) imagem = '1;
        if (prev_v && !prev_p && (!bus.byte_valido || {bus.byte_dc, bus.byte_saida} !== prev_b))
            stab_err++;
        if (conc_prev) ocup_after_conc = ocupado;
        conc_prev = quadro_concluido;
        if (quadro_concluido) begin
            conc_cnt++;
            conc_cyc = cyc;
            conc_valido = bus.byte_valido;
        end
        if (!bus.byte_valido && obs_q.size() > 0 && obs_q.size() < target) gap_cnt++;
        if (!ocupado && obs_q.size() > 0 && obs_q.size() < target) idle_mid++;
        if (bus.byte_valido && bus.byte_pronto) begin
            if (obs_q.size() == 0) first_push_cyc = cyc;
            last_push_cyc = cyc;
            obs_q.push_back({bus.byte_dc, bus.byte_saida});
        end
        prev_v = bus.byte_valido;
        prev_p = bus.byte_pronto;
        prev_b = {bus.byte_dc, bus.byte_saida};
        last_ocupado = ocupado;
        last_valido = bus.byte_valido;
    endtask

    task automatic collect(input int n, input int pct, input int tail);
        obs_q.delete();
        target = n; cyc = 0; stab_err = 0; conc_cnt = 0; gap_cnt = 0; idle_mid = 0;
        first_push_cyc = -1; last_push_cyc = -1; conc_cyc = -1;
        conc_valido = 1'bx; ocup_after_conc = 1'bx; conc_prev = 0; prev_v = 0; prev_p = 0;
        while (obs_q.size() < n && cyc < BUDGET) cycle_step(pct);
        for (int i = 0; i < tail; i++) cycle_step(pct);
    endtask

    task automatic clear_flags();
        start_pulse = 0; upd_mid = 0; hold_upd = 0; sw_at = -1;
    endtask

    task automatic test_reset();
        int fm;
        clear_flags();
        reset = 1'b1;
        atualizar = 1'b1;
        bus.byte_pronto = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.byte_valido !== 1'b0) $display("FAIL reset_valido: got %b want 0", bus.byte_valido); else passes++;
        checks++; if (bus.byte_saida !== 8'h00) $display("FAIL reset_saida: got %h want 00", bus.byte_saida); else passes++;
        checks++; if (bus.byte_dc !== 1'b0) $display("FAIL reset_dc: got %b want 0", bus.byte_dc); else passes++;
        checks++; if (quadro_concluido !== 1'b0) $display("FAIL reset_concluido: got %b want 0", quadro_concluido); else passes++;
        checks++; if (ocupado !== 1'b1) $display("FAIL reset_ocupado: got %b want 1", ocupado); else passes++;
        checks++; if (estado !== 3'd0) $display("FAIL reset_estado: got %0d want 0", estado); else passes++;
        reset = 1'b0;
        atualizar = 1'b0;
        exp_q.delete();
        exp_init();
        collect(6, 100, 3);
        fm = first_mism();
        checks++; if (fm !== -1) $display("FAIL init_stream: index %0d got %h want %h", fm, obs_at(fm), exp_at(fm)); else passes++;
        checks++; if (first_push_cyc !== 1) $display("FAIL init_first_cycle: got %0d want 1", first_push_cyc); else passes++;
        checks++; if (gap_cnt !== 0) $display("FAIL init_gaps: got %0d want 0", gap_cnt); else passes++;
        checks++; if (last_ocupado !== 1'b0) $display("FAIL init_then_idle_ocupado: got %b want 0", last_ocupado); else passes++;
        checks++; if (last_valido !== 1'b0) $display("FAIL init_then_idle_valido: got %b want 0", last_valido); else passes++;
        checks++; if (estado !== 3'd1) $display("FAIL init_then_idle_estado: got %0d want 1", estado); else passes++;
    endtask

    task automatic test_frame_ramp();
        int fm;
        clear_flags();
        imagem = ramp();
        exp_q.delete();
        exp_frame(imagem);
        start_pulse = 1;
        collect(1030, 100, 3);
        clear_flags();
        fm = first_mism();
        checks++; if (fm !== -1) $display("FAIL ramp_stream: index %0d got %h want %h", fm, obs_at(fm), exp_at(fm)); else passes++;
        checks++; if (first_push_cyc !== 2) $display("FAIL ramp_first_cycle: got %0d want 2", first_push_cyc); else passes++;
        checks++; if (gap_cnt !== 0) $display("FAIL ramp_gaps: got %0d want 0", gap_cnt); else passes++;
        checks++; if (conc_cnt !== 1) $display("FAIL ramp_concluido_count: got %0d want 1", conc_cnt); else passes++;
        checks++; if (conc_cyc !== last_push_cyc + 1) $display("FAIL ramp_concluido_cycle: got %0d want %0d", conc_cyc, last_push_cyc + 1); else passes++;
        checks++; if (conc_valido !== 1'b0) $display("FAIL ramp_fim_valido: got %b want 0", conc_valido); else passes++;
        checks++; if (ocup_after_conc !== 1'b0) $display("FAIL ramp_ocupado_after: got %b want 0", ocup_after_conc); else passes++;
    endtask

    task automatic test_backpressure();
        int fm;
        clear_flags();
        imagem = ramp();
        exp_q.delete();
        exp_frame(imagem);
        start_pulse = 1;
        collect(1030, 30, 4);
        clear_flags();
        fm = first_mism();
        checks++; if (fm !== -1) $display("FAIL stall_stream: index %0d got %h want %h", fm, obs_at(fm), exp_at(fm)); else passes++;
        checks++; if (stab_err !== 0) $display("FAIL stall_stability: got %0d unstable cycles want 0", stab_err); else passes++;
        checks++; if (conc_cnt !== 1) $display("FAIL stall_concluido_count: got %0d want 1", conc_cnt); else passes++;
        checks++; if (last_ocupado !== 1'b0) $display("FAIL stall_idle_after: got %b want 0", last_ocupado); else passes++;
    endtask

    task automatic test_tearing();
        int fm;
        clear_flags();
        imagem = ramp();
        exp_q.delete();
        exp_frame(imagem);
        exp_frame('1);
        sw_at = 107;
        upd_mid = 1;
        start_pulse = 1;
        collect(2060, 100, 4);
        clear_flags();
        fm = first_mism();
        checks++; if (fm !== -1) $display("FAIL tear_stream: index %0d got %h want %h", fm, obs_at(fm), exp_at(fm)); else passes++;
        checks++; if (conc_cnt !== 2) $display("FAIL tear_frame_count: got %0d want 2", conc_cnt); else passes++;
        checks++; if (gap_cnt !== 1) $display("FAIL tear_gap_between: got %0d want 1", gap_cnt); else passes++;
        checks++; if (last_ocupado !== 1'b0) $display("FAIL tear_idle_after: got %b want 0", last_ocupado); else passes++;
        checks++; if (last_valido !== 1'b0) $display("FAIL tear_valido_after: got %b want 0", last_valido); else passes++;
    endtask

    task automatic test_reset_mid();
        int fm;
        clear_flags();
        imagem = ramp();
        upd_mid = 1;
        start_pulse = 1;
        collect(506, 100, 0);
        clear_flags();
        @(negedge clk);
        checks++; if (bus.byte_valido !== 1'b1 || {bus.byte_dc, bus.byte_saida} !== {1'b1, 8'hF4})
            $display("FAIL midreset_byte500: got v=%b %h want v=1 1f4", bus.byte_valido, {bus.byte_dc, bus.byte_saida}); else passes++;
        bus.byte_pronto = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.byte_valido !== 1'b0) $display("FAIL midreset_valido: got %b want 0", bus.byte_valido); else passes++;
        checks++; if (quadro_concluido !== 1'b0) $display("FAIL midreset_concluido: got %b want 0", quadro_concluido); else passes++;
        reset = 1'b0;
        exp_q.delete();
        exp_init();
        collect(6, 100, 4);
        fm = first_mism();
        checks++; if (fm !== -1) $display("FAIL midreset_init_stream: index %0d got %h want %h", fm, obs_at(fm), exp_at(fm)); else passes++;
        checks++; if (first_push_cyc !== 1) $display("FAIL midreset_first_cycle: got %0d want 1", first_push_cyc); else passes++;
        checks++; if (conc_cnt !== 0) $display("FAIL midreset_no_concluido: got %0d want 0", conc_cnt); else passes++;
        checks++; if (last_ocupado !== 1'b0) $display("FAIL midreset_pendente_cleared: got ocupado %b want 0", last_ocupado); else passes++;
    endtask

    task automatic test_back_to_back();
        int fm;
        clear_flags();
        imagem = ~ramp();
        exp_q.delete();
        exp_frame(imagem);
        exp_frame(imagem);
        hold_upd = 1;
        collect(2060, 100, 0);
        clear_flags();
        fm = first_mism();
        checks++; if (fm !== -1) $display("FAIL b2b_stream: index %0d got %h want %h", fm, obs_at(fm), exp_at(fm)); else passes++;
        checks++; if (gap_cnt !== 1) $display("FAIL b2b_single_fim_gap: got %0d want 1", gap_cnt); else passes++;
        checks++; if (idle_mid !== 0) $display("FAIL b2b_no_idle: got %0d idle cycles want 0", idle_mid); else passes++;
        checks++; if (conc_cnt !== 1) $display("FAIL b2b_concluido_mid: got %0d want 1", conc_cnt); else passes++;
        // the request held during the second frame leaves exactly one more frame pending
        exp_q.delete();
        exp_frame(imagem);
        collect(1030, 100, 4);
        fm = first_mism();
        checks++; if (fm !== -1) $display("FAIL b2b_pending_stream: index %0d got %h want %h", fm, obs_at(fm), exp_at(fm)); else passes++;
        checks++; if (conc_cnt !== 2) $display("FAIL b2b_pending_concluido: got %0d want 2", conc_cnt); else passes++;
        checks++; if (last_ocupado !== 1'b0) $display("FAIL b2b_idle_after: got %b want 0", last_ocupado); else passes++;
    endtask

    initial begin
        test_reset();
        test_frame_ramp();
        test_backpressure();
        test_tearing();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
